// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_decode
//  Description : Registered MIPS decode stage. Turns a 32-bit instruction word
//                into the ALU opcode set (ALUFun, Sign) and the datapath
//                control signals, held in a one-entry pipeline register with
//                valid/ready handshakes on both sides, a flush input and an
//                illegal-instruction flag.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    PC_W        width of the PC carried alongside the instruction
//  Ports
//    clk, reset            clock (rising edge), synchronous active-high reset
//    in_valid/in_ready     upstream handshake; transfer when both are high
//    in_instr, in_pc       instruction word and its PC
//    flush                 squash held and incoming instruction
//    out_valid/out_ready   downstream handshake
//    out_pc, out_instr     registered PC and instruction
//    ALUFun, Sign          ALU opcode and signed-compare select
//    ALUSrc1, ALUSrc2      A = shamt, B = immediate operand selects
//    ExtOp, LUOp           immediate sign-extend / shift-left-16 selects
//    RegDst                0 = rt, 1 = rd, 2 = $31
//    RegWr, MemRd, MemWr, Branch, Jump, JumpReg   datapath controls
//    illegal               opcode/funct not supported
//  Optional feature (macro DECODE_STATS_EN)
//    stat_decoded          count of accepted transfers (32 bit, wrapping)
//    stat_illegal          count of accepted illegal transfers (16 bit)
// ============================================================================
module alu_ctrl_decode #(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [5:0]      ALUFun,
  output logic            Sign,
  output logic            ALUSrc1,
  output logic            ALUSrc2,
  output logic            ExtOp,
  output logic            LUOp,
  output logic [1:0]      RegDst,
  output logic            RegWr,
  output logic            MemRd,
  output logic            MemWr,
  output logic            Branch,
  output logic            Jump,
  output logic            JumpReg,
  output logic            illegal
`ifdef DECODE_STATS_EN
  ,
  output logic [31:0]     stat_decoded,
  output logic [15:0]     stat_illegal
`endif
);

  // --------------------------------------------------------------------------
  // ALU opcodes
  // --------------------------------------------------------------------------
  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

  // --------------------------------------------------------------------------
  // Primary opcodes
  // --------------------------------------------------------------------------
  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  // --------------------------------------------------------------------------
  // R-type function codes
  // --------------------------------------------------------------------------
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] DST_RT = 2'd0;
  localparam logic [1:0] DST_RD = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  // --------------------------------------------------------------------------
  // Instruction fields
  // --------------------------------------------------------------------------
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;

  assign opcode = in_instr[31:26];
  assign funct  = in_instr[5:0];
  assign rt     = in_instr[20:16];

  // --------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // --------------------------------------------------------------------------
  logic [5:0] dec_alufun;
  logic       dec_sign;
  logic       dec_src1;
  logic       dec_src2;
  logic       dec_ext;
  logic       dec_lu;
  logic [1:0] dec_regdst;
  logic       dec_regwr;
  logic       dec_memrd;
  logic       dec_memwr;
  logic       dec_branch;
  logic       dec_jump;
  logic       dec_jumpreg;
  logic       dec_illegal;

  always_comb begin
    dec_alufun  = ALU_ADD;
    dec_sign    = 1'b1;
    dec_src1    = 1'b0;
    dec_src2    = 1'b0;
    dec_ext     = 1'b0;
    dec_lu      = 1'b0;
    dec_regdst  = DST_RT;
    dec_regwr   = 1'b0;
    dec_memrd   = 1'b0;
    dec_memwr   = 1'b0;
    dec_branch  = 1'b0;
    dec_jump    = 1'b0;
    dec_jumpreg = 1'b0;
    dec_illegal = 1'b0;

    case (opcode)
      OP_RTYPE: begin
        dec_regdst = DST_RD;
        dec_regwr  = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: dec_alufun = ALU_ADD;
          FN_SUB, FN_SUBU: dec_alufun = ALU_SUB;
          FN_AND:          dec_alufun = ALU_AND;
          FN_OR:           dec_alufun = ALU_OR;
          FN_XOR:          dec_alufun = ALU_XOR;
          FN_NOR:          dec_alufun = ALU_NOR;
          FN_SLT:          dec_alufun = ALU_LT;
          FN_SLTU: begin
            dec_alufun = ALU_LT;
            dec_sign   = 1'b0;
          end
          FN_SLL: begin
            dec_alufun = ALU_SLL;
            dec_src1   = 1'b1;
          end
          FN_SRL: begin
            dec_alufun = ALU_SRL;
            dec_src1   = 1'b1;
          end
          FN_SRA: begin
            dec_alufun = ALU_SRA;
            dec_src1   = 1'b1;
          end
          FN_JR: begin
            dec_jumpreg = 1'b1;
            dec_regwr   = 1'b0;
          end
          FN_JALR: begin
            dec_jumpreg = 1'b1;
            dec_regdst  = DST_RA;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        dec_src2  = 1'b1;
        dec_ext   = 1'b1;
        dec_regwr = 1'b1;
      end
      OP_ANDI: begin
        dec_alufun = ALU_AND;
        dec_src2   = 1'b1;
        dec_regwr  = 1'b1;
      end
      OP_ORI: begin
        dec_alufun = ALU_OR;
        dec_src2   = 1'b1;
        dec_regwr  = 1'b1;
      end
      OP_SLTI: begin
        dec_alufun = ALU_LT;
        dec_src2   = 1'b1;
        dec_ext    = 1'b1;
        dec_regwr  = 1'b1;
      end
      OP_SLTIU: begin
        dec_alufun = ALU_LT;
        dec_sign   = 1'b0;
        dec_src2   = 1'b1;
        dec_ext    = 1'b1;
        dec_regwr  = 1'b1;
      end
      OP_LUI: begin
        dec_src2  = 1'b1;
        dec_lu    = 1'b1;
        dec_regwr = 1'b1;
      end
      OP_LW: begin
        dec_src2  = 1'b1;
        dec_memrd = 1'b1;
        dec_regwr = 1'b1;
      end
      OP_SW: begin
        dec_src2  = 1'b1;
        dec_memwr = 1'b1;
      end
      OP_BEQ: begin
        dec_alufun = ALU_EQ;
        dec_branch = 1'b1;
      end
      OP_BNE: begin
        dec_alufun = ALU_NEQ;
        dec_branch = 1'b1;
      end
      OP_BLEZ: begin
        dec_alufun = ALU_LEZ;
        dec_branch = 1'b1;
      end
      OP_BGTZ: begin
        dec_alufun = ALU_GTZ;
        dec_branch = 1'b1;
      end
      // Only bltz (rt == 0) is supported within the REGIMM group.
      OP_REGIMM: begin
        if (rt == 5'd0) begin
          dec_alufun = ALU_LTZ;
          dec_branch = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OP_J: begin
        dec_jump = 1'b1;
      end
      OP_JAL: begin
        dec_jump   = 1'b1;
        dec_regwr  = 1'b1;
        dec_regdst = DST_RA;
      end
      default: dec_illegal = 1'b1;
    endcase

    // An unsupported encoding falls back to the neutral default bundle so
    // that no architectural side effect can be triggered by it.
    if (dec_illegal) begin
      dec_alufun  = ALU_ADD;
      dec_sign    = 1'b1;
      dec_src1    = 1'b0;
      dec_src2    = 1'b0;
      dec_ext     = 1'b0;
      dec_lu      = 1'b0;
      dec_regdst  = DST_RT;
      dec_regwr   = 1'b0;
      dec_memrd   = 1'b0;
      dec_memwr   = 1'b0;
      dec_branch  = 1'b0;
      dec_jump    = 1'b0;
      dec_jumpreg = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic transfer;

  // The register may be refilled whenever it is empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign transfer = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Pipeline register. Priority: reset > flush > transfer > drain.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_instr <= '0;
      ALUFun    <= ALU_ADD;
      Sign      <= 1'b0;
      ALUSrc1   <= 1'b0;
      ALUSrc2   <= 1'b0;
      ExtOp     <= 1'b0;
      LUOp      <= 1'b0;
      RegDst    <= DST_RT;
      RegWr     <= 1'b0;
      MemRd     <= 1'b0;
      MemWr     <= 1'b0;
      Branch    <= 1'b0;
      Jump      <= 1'b0;
      JumpReg   <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      // Controls return to their reset values; the PC/instruction fields are
      // left as they were since they are meaningless while out_valid is low.
      out_valid <= 1'b0;
      ALUFun    <= ALU_ADD;
      Sign      <= 1'b0;
      ALUSrc1   <= 1'b0;
      ALUSrc2   <= 1'b0;
      ExtOp     <= 1'b0;
      LUOp      <= 1'b0;
      RegDst    <= DST_RT;
      RegWr     <= 1'b0;
      MemRd     <= 1'b0;
      MemWr     <= 1'b0;
      Branch    <= 1'b0;
      Jump      <= 1'b0;
      JumpReg   <= 1'b0;
      illegal   <= 1'b0;
    end else if (transfer) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_instr <= in_instr;
      ALUFun    <= dec_alufun;
      Sign      <= dec_sign;
      ALUSrc1   <= dec_src1;
      ALUSrc2   <= dec_src2;
      ExtOp     <= dec_ext;
      LUOp      <= dec_lu;
      RegDst    <= dec_regdst;
      RegWr     <= dec_regwr;
      MemRd     <= dec_memrd;
      MemWr     <= dec_memwr;
      Branch    <= dec_branch;
      Jump      <= dec_jump;
      JumpReg   <= dec_jumpreg;
      illegal   <= dec_illegal;
    end else if (out_ready) begin
      // Drained with nothing behind it; bundle fields keep their last values.
      out_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Decode statistics
  // --------------------------------------------------------------------------
`ifdef DECODE_STATS_EN
  logic        counted;
  logic [31:0] cnt_decoded;
  logic [15:0] cnt_illegal;

  // Flushed offers never reach the register, so they are not counted.
  assign counted = transfer && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_decoded <= '0;
      cnt_illegal <= '0;
    end else if (counted) begin
      cnt_decoded <= cnt_decoded + 32'd1;
      if (dec_illegal) begin
        cnt_illegal <= cnt_illegal + 16'd1;
      end
    end
  end

  assign stat_decoded = cnt_decoded;
  assign stat_illegal = cnt_illegal;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl_decode
//  Description : Self-checking bench for alu_ctrl_decode. Directed steps from
//                the test plan followed by randomized traffic compared against
//                a mnemonic-level reference model of decode and handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_decode;

  typedef struct packed {
    logic [5:0] alufun;
    logic       sign;
    logic       src1;
    logic       src2;
    logic       ext;
    logic       lu;
    logic [1:0] regdst;
    logic       regwr;
    logic       memrd;
    logic       memwr;
    logic       branch;
    logic       jump;
    logic       jumpreg;
    logic       illegal;
  } ctl_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [5:0]  ALUFun;
  logic        Sign, ALUSrc1, ALUSrc2, ExtOp, LUOp;
  logic [1:0]  RegDst;
  logic        RegWr, MemRd, MemWr, Branch, Jump, JumpReg, illegal;
`ifdef DECODE_STATS_EN
  logic [31:0] stat_decoded;
  logic [15:0] stat_illegal;
`endif

  alu_ctrl_decode #(.PC_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .ALUFun    (ALUFun),
    .Sign      (Sign),
    .ALUSrc1   (ALUSrc1),
    .ALUSrc2   (ALUSrc2),
    .ExtOp     (ExtOp),
    .LUOp      (LUOp),
    .RegDst    (RegDst),
    .RegWr     (RegWr),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .Branch    (Branch),
    .Jump      (Jump),
    .JumpReg   (JumpReg),
    .illegal   (illegal)
`ifdef DECODE_STATS_EN
    ,
    .stat_decoded (stat_decoded),
    .stat_illegal (stat_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state of the output register
  logic        m_valid;
  ctl_t        m_ctl;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_decoded;
  logic [15:0] m_illegal;

  ctl_t obs_ctl;
  assign obs_ctl = {ALUFun, Sign, ALUSrc1, ALUSrc2, ExtOp, LUOp, RegDst,
                    RegWr, MemRd, MemWr, Branch, Jump, JumpReg, illegal};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---- Reference model: instruction -> mnemonic -> control bundle ----
  function automatic string mnem(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'd0) begin
      case (fn)
        6'h20: return "add";  6'h21: return "addu";
        6'h22: return "sub";  6'h23: return "subu";
        6'h24: return "and";  6'h25: return "or";
        6'h26: return "xor";  6'h27: return "nor";
        6'h2A: return "slt";  6'h2B: return "sltu";
        6'h00: return "sll";  6'h02: return "srl";
        6'h03: return "sra";  6'h08: return "jr";
        6'h09: return "jalr";
        default: return "bad";
      endcase
    end
    case (op)
      6'h01: return (ins[20:16] == 5'd0) ? "bltz" : "bad";
      6'h02: return "j";     6'h03: return "jal";
      6'h04: return "beq";   6'h05: return "bne";
      6'h06: return "blez";  6'h07: return "bgtz";
      6'h08: return "addi";  6'h09: return "addiu";
      6'h0A: return "slti";  6'h0B: return "sltiu";
      6'h0C: return "andi";  6'h0D: return "ori";
      6'h0F: return "lui";   6'h23: return "lw";
      6'h2B: return "sw";
      default: return "bad";
    endcase
  endfunction

  function automatic ctl_t ref_ctl(input logic [31:0] ins);
    ctl_t  c;
    string m;
    m = mnem(ins);
    c = '0;
    c.sign = 1'b1;
    if (m == "bad") begin
      c.illegal = 1'b1;
      return c;
    end
    if (ins[31:26] == 6'd0) begin
      c.regdst = 2'd1;
      c.regwr  = 1'b1;
    end
    case (m)
      "sub", "subu": c.alufun = 6'b000001;
      "and":  c.alufun = 6'b011000;
      "or":   c.alufun = 6'b011110;
      "xor":  c.alufun = 6'b010110;
      "nor":  c.alufun = 6'b010001;
      "slt":  c.alufun = 6'b110101;
      "sltu": begin c.alufun = 6'b110101; c.sign = 1'b0; end
      "sll":  begin c.alufun = 6'b100000; c.src1 = 1'b1; end
      "srl":  begin c.alufun = 6'b100001; c.src1 = 1'b1; end
      "sra":  begin c.alufun = 6'b100011; c.src1 = 1'b1; end
      "jr":   begin c.jumpreg = 1'b1; c.regwr = 1'b0; end
      "jalr": begin c.jumpreg = 1'b1; c.regdst = 2'd2; end
      "addi", "addiu": begin c.src2 = 1'b1; c.ext = 1'b1; c.regwr = 1'b1; end
      "andi": begin c.alufun = 6'b011000; c.src2 = 1'b1; c.regwr = 1'b1; end
      "ori":  begin c.alufun = 6'b011110; c.src2 = 1'b1; c.regwr = 1'b1; end
      "slti": begin c.alufun = 6'b110101; c.src2 = 1'b1; c.ext = 1'b1; c.regwr = 1'b1; end
      "sltiu": begin
        c.alufun = 6'b110101; c.sign = 1'b0; c.src2 = 1'b1; c.ext = 1'b1; c.regwr = 1'b1;
      end
      "lui":  begin c.src2 = 1'b1; c.lu = 1'b1; c.regwr = 1'b1; end
      "lw":   begin c.src2 = 1'b1; c.memrd = 1'b1; c.regwr = 1'b1; end
      "sw":   begin c.src2 = 1'b1; c.memwr = 1'b1; end
      "beq":  begin c.alufun = 6'b110011; c.branch = 1'b1; end
      "bne":  begin c.alufun = 6'b110001; c.branch = 1'b1; end
      "blez": begin c.alufun = 6'b111101; c.branch = 1'b1; end
      "bgtz": begin c.alufun = 6'b111111; c.branch = 1'b1; end
      "bltz": begin c.alufun = 6'b111011; c.branch = 1'b1; end
      "j":    c.jump = 1'b1;
      "jal":  begin c.jump = 1'b1; c.regwr = 1'b1; c.regdst = 2'd2; end
      default: ;
    endcase
    return c;
  endfunction

  // ---- Compare registered outputs to the model ----
  task automatic check_outputs();
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("ctl", {44'd0, obs_ctl}, {44'd0, m_ctl});
    chk("out_pc", {32'd0, out_pc}, {32'd0, m_pc});
    chk("out_instr", {32'd0, out_instr}, {32'd0, m_instr});
`ifdef DECODE_STATS_EN
    chk("stat_decoded", {32'd0, stat_decoded}, {32'd0, m_decoded});
    chk("stat_illegal", {48'd0, stat_illegal}, {48'd0, m_illegal});
`endif
  endtask

  // One clock: drive at negedge, check in_ready, advance model, check outputs
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rs);
    logic exp_ready;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    reset     = rs;
    #1;
    exp_ready = !m_valid || ordy;
    if (!rs) chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
    if (rs) begin
      m_valid = 1'b0; m_ctl = '0; m_pc = '0; m_instr = '0;
      m_decoded = '0; m_illegal = '0;
    end else if (fl) begin
      m_valid = 1'b0; m_ctl = '0;
    end else if (v && exp_ready) begin
      m_valid = 1'b1; m_ctl = ref_ctl(ins); m_pc = pc; m_instr = ins;
      m_decoded = m_decoded + 32'd1;
      if (mnem(ins) == "bad") m_illegal = m_illegal + 16'd1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  logic [5:0] ops [21] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h02,
                           6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09,
                           6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] fns [15] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                           6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    ins = $urandom;
    if ($urandom_range(0, 9) >= 2) begin
      ins[31:26] = ops[$urandom_range(0, 20)];
      if (ins[31:26] == 6'h00) ins[5:0] = fns[$urandom_range(0, 14)];
      if (ins[31:26] == 6'h01 && $urandom_range(0, 3) != 0) ins[20:16] = 5'd0;
    end
    return ins;
  endfunction

  initial begin
    in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0; reset = 1;
    m_valid = 0; m_ctl = '0; m_pc = '0; m_instr = '0; m_decoded = '0; m_illegal = '0;
    @(negedge clk);

    // Reset
    cycle(0, 32'h0, 32'h0, 1, 0, 1);
    cycle(0, 32'h0, 32'h0, 1, 0, 1);
    chk("rst_alufun", {58'd0, ALUFun}, 64'd0);
    chk("rst_sign", {63'd0, Sign}, 64'd0);

    // add $3,$1,$2
    cycle(1, 32'h00221820, 32'h100, 1, 0, 0);
    chk("add_valid", {63'd0, out_valid}, 64'd1);
    chk("add_alufun", {58'd0, ALUFun}, 64'h00);
    chk("add_regdst", {62'd0, RegDst}, 64'd1);
    chk("add_regwr", {63'd0, RegWr}, 64'd1);
    chk("add_src2", {63'd0, ALUSrc2}, 64'd0);
    chk("add_illegal", {63'd0, illegal}, 64'd0);

    // slti then sltu
    cycle(1, 32'h2822FFFF, 32'h104, 1, 0, 0);
    chk("slti_alufun", {58'd0, ALUFun}, 64'h35);
    chk("slti_bits", {60'd0, Sign, ALUSrc2, ExtOp, RegDst == 2'd0}, 64'hF);
    cycle(1, 32'h0022182B, 32'h108, 1, 0, 0);
    chk("sltu_alufun", {58'd0, ALUFun}, 64'h35);
    chk("sltu_sign", {63'd0, Sign}, 64'd0);

    // sra, beq
    cycle(1, 32'h00021883, 32'h10C, 1, 0, 0);
    chk("sra_alufun", {58'd0, ALUFun}, 64'h23);
    chk("sra_src1", {63'd0, ALUSrc1}, 64'd1);
    cycle(1, 32'h10220003, 32'h110, 1, 0, 0);
    chk("beq_alufun", {58'd0, ALUFun}, 64'h33);
    chk("beq_bits", {62'd0, Branch, RegWr}, 64'h2);

    // illegal
    cycle(1, 32'hFC000000, 32'h114, 1, 0, 0);
    chk("ill_bits", {61'd0, illegal, RegWr, MemWr}, 64'h4);
`ifdef DECODE_STATS_EN
    chk("ill_stat_dec", {32'd0, stat_decoded}, 64'd6);
    chk("ill_stat_ill", {48'd0, stat_illegal}, 64'd1);
`endif

    // Stall: hold add for 3 cycles, then back-to-back transfers
    cycle(1, 32'h00221820, 32'h200, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h8C220000, 32'h204, 0, 0, 0);
      chk("stall_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_instr", {32'd0, out_instr}, 64'h00221820);
      chk("stall_pc", {32'd0, out_pc}, 64'h200);
    end
    cycle(1, 32'h8C220000, 32'h204, 1, 0, 0);
    chk("b2b_pc0", {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'h204});
    cycle(1, 32'h34220005, 32'h208, 1, 0, 0);
    chk("b2b_pc1", {31'd0, out_valid, out_pc}, {31'd0, 1'b1, 32'h208});

    // Flush with an offered sw
    cycle(1, 32'hAC220004, 32'h20C, 1, 1, 0);
    chk("flush_bits", {62'd0, out_valid, MemWr}, 64'd0);

    // Reset during a stall
    cycle(1, 32'h00221822, 32'h300, 1, 0, 0);
    cycle(1, 32'h00221820, 32'h304, 0, 0, 0);
    cycle(1, 32'h00221820, 32'h304, 0, 0, 1);
    chk("rst_stall", {57'd0, out_valid, ALUFun}, 64'd0);

    // Drain
    cycle(1, 32'h0C000010, 32'h400, 1, 0, 0);
    cycle(0, 32'h0, 32'h0, 1, 0, 0);
    chk("drain_valid", {63'd0, out_valid}, 64'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 63) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
